lc3_mem_access: RTL and testbench
=================================

Name: lc3_mem_access

Overview:
- Memory-stage responder for the LC3 pipeline.
- Consumes the controller's mem_state command and the execute-stage address/data, and performs the data-memory transaction over a req/ack interface.
- Returns a single-cycle complete_data pulse plus load data.
- Handles the two-step indirect sequences: LDI is mem_state 1→0, STI is mem_state 1→2. The pointer fetched in step 1 becomes the address of step 2.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 255, maximum cycles the block waits for dmem_ack before aborting.
- TO_W, $clog2(TIMEOUT+1), width of the timeout counter (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_state  in  2  command: 0 read, 1 indirect pointer read, 2 write, 3 idle.
- M_Addr  in  DATA_W  effective address from execute.
- M_Data  in  DATA_W  store data from execute/bypass.
- dmem_rd  out  1  read request, level, held until ack.
- dmem_wr  out  1  write request, level, held until ack.
- dmem_addr  out  DATA_W  memory address.
- dmem_din  out  DATA_W  write data to memory.
- dmem_dout  in  DATA_W  read data from memory, valid with dmem_ack.
- dmem_ack  in  1  memory completion.
- complete_data  out  1  one-cycle completion pulse to the controller.
- memout  out  DATA_W  last loaded data, to writeback.
- mem_err  out  1  high together with complete_data when the access timed out.

Behaviour:
- Reset values: all outputs 0; state IDLE; ind_valid=0; ptr=0; timeout counter=0.
- States:
  - IDLE: waiting for a command.
  - ACCESS: request outstanding.
  - HOLD: completion cycle.
- IDLE with mem_state∈{0,1,2} → next edge enter ACCESS and register the transaction:
  - op ← mem_state.
  - dmem_addr ← ptr if (ind_valid && mem_state∈{0,2}), else M_Addr.
  - dmem_din ← M_Data.
  - dmem_rd ← (mem_state∈{0,1}); dmem_wr ← (mem_state==2).
  - counter ← 0.
- IDLE with mem_state==3: stay IDLE and clear ind_valid, which abandons any partial indirect.
- ACCESS:
  - dmem_rd, dmem_wr, dmem_addr and dmem_din are held stable; mem_state changes are ignored.
  - The counter increments each cycle without ack.
- ACCESS, dmem_ack=1 sampled → next edge:
  - Drop dmem_rd/dmem_wr and enter HOLD with complete_data=1.
  - op 0: memout ← dmem_dout; ind_valid ← 0.
  - op 1: ptr ← dmem_dout; ind_valid ← 1; memout unchanged.
  - op 2: ind_valid ← 0.
- ACCESS, counter==TIMEOUT without ack → next edge:
  - Drop requests and enter HOLD with complete_data=1 and mem_err=1.
  - memout ← 0; ind_valid ← 0.
- HOLD: lasts exactly one cycle, then IDLE; complete_data and mem_err return to 0. HOLD guarantees the controller's mem_state update is seen before a new command is accepted, so there is no duplicate access.
- Latency:
  - mem_state valid in cycle 0 → dmem_rd/dmem_wr high in cycle 1.
  - With ack in cycle 1, complete_data is high in cycle 2 (minimum 2 cycles).
  - In general, complete_data is high in the cycle after the ack cycle.
- Ack already high when the request first asserts is legal and counts as an immediate ack.
- dmem_ack while in IDLE or HOLD is ignored.
- memout holds its value until the next successful op-0 read or a timeout.
- rst mid-access: requests drop at the reset edge and no complete_data is issued; the memory side must tolerate the abandoned request.

Decomposition:
- Package lc3_mem_pkg:
  - mem_cmd_t enum: MEM_RD=2'h0, MEM_IND=2'h1, MEM_WR=2'h2, MEM_IDLE=2'h3. The controller already drives this encoding on mem_state, and its mem_state assignments should be moved onto these constants.
  - mem_fsm_t enum: IDLE, ACCESS, HOLD.
- Optional sub-module mem_timeout_ctr (clear, enable, expired) parameterised by TIMEOUT.

Test Plan:
- LD:
  - Stimulus: mem_state=0, M_Addr=16'h3000; memory acks 3 cycles after request with 16'hBEEF.
  - Required: dmem_rd=1 with addr 16'h3000 for 3 cycles; complete_data pulses once; memout=16'hBEEF; mem_err=0.
- LDI:
  - Stimulus: mem_state=1, M_Addr=16'h3010; mem[3010]=16'h4000; after the pulse mem_state=0; mem[4000]=16'h1234.
  - Required: second request addr=16'h4000 (not M_Addr); two complete_data pulses; memout=16'h1234; ind_valid cleared.
- STI:
  - Stimulus: mem_state=1 at 16'h3020 returning 16'h5000; then mem_state=2 with M_Data=16'hA5A5.
  - Required: dmem_wr with addr 16'h5000, din 16'hA5A5; memout unchanged.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_state=0, no ack.
  - Required: request held 9 cycles, then dropped; complete_data=mem_err=1 for one cycle; memout=0.
- Abort:
  - Stimulus (first): indirect step completes, then mem_state=3 for one cycle, then mem_state=0 with M_Addr=16'h3100.
  - Required: read addr=16'h3100, not ptr.
  - Stimulus (second): rst asserted in ACCESS.
  - Required: dmem_rd=0 next cycle; no complete_data pulse.
- Back-to-back:
  - Stimulus: mem_state held at 0 across completion (controller slow).
  - Required: exactly one HOLD cycle, then a fresh request; ack during HOLD is ignored.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared encodings for the LC3 memory stage: controller command codes on
// mem_state and the responder FSM states.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    MEM_RD   = 2'h0,
    MEM_IND  = 2'h1,
    MEM_WR   = 2'h2,
    MEM_IDLE = 2'h3
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } mem_fsm_t;

  // Both the plain load and the pointer fetch of an indirect issue a read.
  function automatic logic cmd_is_read(mem_cmd_t cmd);
    return (cmd == MEM_RD) || (cmd == MEM_IND);
  endfunction

  // Second step of LDI/STI: these commands may consume a fetched pointer.
  function automatic logic cmd_takes_ptr(mem_cmd_t cmd);
    return (cmd == MEM_RD) || (cmd == MEM_WR);
  endfunction

endpackage

// File: rtl/lc3_mem_access_if.sv
// Data-memory request/acknowledge bus between the LC3 memory stage (master)
// and the data memory (slave).
interface lc3_mem_access_if #(
  parameter int DATA_W = 16
);
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              ack;

  modport master (
    output rd, wr, addr, din,
    input  dout, ack
  );

  modport slave (
    input  rd, wr, addr, din,
    output dout, ack
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter for an outstanding memory request; expired is high
// once the count reaches TIMEOUT.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  assign expired = (cnt_q == TO_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3_mem_access.sv
// LC3 memory-stage responder: runs one data-memory transaction per controller
// command, chaining LDI/STI through a fetched pointer, and pulses complete_data.
module lc3_mem_access
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_state,
  input  logic [DATA_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  lc3_mem_access_if.master  dmem,
  output logic              complete_data,
  output logic [DATA_W-1:0] memout,
  output logic              mem_err
);

  mem_fsm_t          state_q, state_d;
  mem_cmd_t          op_q, op_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] ptr_q, ptr_d;
  logic              ind_valid_q, ind_valid_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic              complete_q, complete_d;
  logic              err_q, err_d;

  mem_cmd_t          cmd;
  logic              ctr_clear;
  logic              ctr_enable;
  logic              ctr_expired;

  assign cmd = mem_cmd_t'(mem_state);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

  // The counter only runs while a request is outstanding and is zero on entry.
  assign ctr_clear  = (state_q != ACCESS);
  assign ctr_enable = (state_q == ACCESS) && !dmem.ack;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    din_d       = din_q;
    ptr_d       = ptr_q;
    ind_valid_d = ind_valid_q;
    memout_d    = memout_q;
    complete_d  = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd == MEM_IDLE) begin
          // An idle command between the two steps abandons the indirect.
          ind_valid_d = 1'b0;
        end else begin
          state_d = ACCESS;
          op_d    = cmd;
          addr_d  = (ind_valid_q && cmd_takes_ptr(cmd)) ? ptr_q : M_Addr;
          din_d   = M_Data;
          rd_d    = cmd_is_read(cmd);
          wr_d    = (cmd == MEM_WR);
        end
      end

      ACCESS: begin
        if (dmem.ack) begin
          state_d    = HOLD;
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          complete_d = 1'b1;
          case (op_q)
            MEM_RD: begin
              memout_d    = dmem.dout;
              ind_valid_d = 1'b0;
            end
            MEM_IND: begin
              ptr_d       = dmem.dout;
              ind_valid_d = 1'b1;
            end
            default: begin
              ind_valid_d = 1'b0;
            end
          endcase
        end else if (ctr_expired) begin
          state_d     = HOLD;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          complete_d  = 1'b1;
          err_d       = 1'b1;
          memout_d    = '0;
          ind_valid_d = 1'b0;
        end
      end

      // One dead cycle lets the controller retire its command before the
      // next one is sampled, so a slow controller never triggers a repeat.
      HOLD: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= MEM_IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      ptr_q       <= '0;
      ind_valid_q <= 1'b0;
      memout_q    <= '0;
      complete_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      ptr_q       <= ptr_d;
      ind_valid_q <= ind_valid_d;
      memout_q    <= memout_d;
      complete_q  <= complete_d;
      err_q       <= err_d;
    end
  end

  assign dmem.rd       = rd_q;
  assign dmem.wr       = wr_q;
  assign dmem.addr     = addr_q;
  assign dmem.din      = din_q;
  assign complete_data = complete_q;
  assign memout        = memout_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Randomised bench for lc3_mem_access against a transaction-level model of
// the memory stage (sparse memory, pointer/indirect state, last-load register).
module tb_lc3_mem_access;
  import lc3_mem_pkg::*;

  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mem_state;
  logic [DW-1:0] M_Addr;
  logic [DW-1:0] M_Data;
  logic          complete_data;
  logic [DW-1:0] memout;
  logic          mem_err;

  lc3_mem_access_if #(.DATA_W(DW)) dmem_if ();

  lc3_mem_access #(
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_state     (mem_state),
    .M_Addr        (M_Addr),
    .M_Data        (M_Data),
    .dmem          (dmem_if),
    .complete_data (complete_data),
    .memout        (memout),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] memout_m = '0;
  logic [DW-1:0] ptr_m    = '0;
  bit            ind_m    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mem_fetch(input logic [DW-1:0] a, output logic [DW-1:0] v);
    if (!mem_m.exists(int'(a))) mem_m[int'(a)] = DW'($urandom);
    v = mem_m[int'(a)];
  endtask

  // Called at a negedge with the DUT idle. delay<0 means the memory never acks.
  task automatic run_txn(input logic [1:0] cmd, input logic [DW-1:0] a,
                         input logic [DW-1:0] d, input int delay, input bit hold_cmd);
    logic [DW-1:0] ea;
    logic [DW-1:0] rv;
    int  ncyc;
    bit  done;
    bit  is_rd;
    bit  timed_out;
    ea        = (ind_m && cmd != 2'd1) ? ptr_m : a;
    is_rd     = (cmd != 2'd2);
    timed_out = (delay < 0);
    mem_fetch(ea, rv);
    mem_state     = cmd;
    M_Addr        = a;
    M_Data        = d;
    dmem_if.ack   = (delay == 0);
    dmem_if.dout  = (delay == 0) ? rv : DW'($urandom);
    ncyc = 0;
    done = 1'b0;
    for (int i = 0; i < TO + 6 && !done; i++) begin
      @(negedge clk);
      if (complete_data) begin
        done = 1'b1;
      end else begin
        ncyc++;
        check_eq("req_rd", dmem_if.rd, is_rd);
        check_eq("req_wr", dmem_if.wr, !is_rd);
        check_eq("req_addr", dmem_if.addr, ea);
        check_eq("req_din", dmem_if.din, d);
        mem_state    = 2'($urandom);
        M_Addr       = DW'($urandom);
        M_Data       = DW'($urandom);
        dmem_if.ack  = !timed_out && (ncyc == delay + 1);
        dmem_if.dout = dmem_if.ack ? rv : DW'($urandom);
      end
    end
    check_eq("complete_seen", done, 1'b1);
    if (!done) return;
    check_eq("req_cycles", ncyc, timed_out ? TO + 1 : delay + 1);
    check_eq("req_drop", {dmem_if.rd, dmem_if.wr}, 2'b00);
    check_eq("mem_err", mem_err, timed_out);
    if (timed_out) begin
      memout_m = '0;
      ind_m    = 1'b0;
    end else begin
      case (cmd)
        2'd0: begin memout_m = rv; ind_m = 1'b0; end
        2'd1: begin ptr_m = rv; ind_m = 1'b1; end
        default: begin mem_m[int'(ea)] = d; ind_m = 1'b0; end
      endcase
    end
    check_eq("memout", memout, memout_m);
    // Completion cycle: anything the memory or controller does now is ignored.
    dmem_if.ack  = 1'($urandom);
    dmem_if.dout = DW'($urandom);
    mem_state    = hold_cmd ? cmd : 2'($urandom);
    @(negedge clk);
    check_eq("pulse_len", complete_data, 1'b0);
    check_eq("err_len", mem_err, 1'b0);
    check_eq("hold_no_req", {dmem_if.rd, dmem_if.wr}, 2'b00);
    check_eq("memout_hold", memout, memout_m);
    dmem_if.ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    mem_state = 2'd3;
    ind_m     = 1'b0;
    for (int i = 0; i < n; i++) begin
      dmem_if.ack = 1'($urandom);
      @(negedge clk);
      check_eq("idle_req", {dmem_if.rd, dmem_if.wr}, 2'b00);
      check_eq("idle_complete", complete_data, 1'b0);
    end
    dmem_if.ack = 1'b0;
  endtask

  task automatic reset_mid_access();
    mem_state   = 2'd0;
    M_Addr      = DW'($urandom);
    dmem_if.ack = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_rd", dmem_if.rd, 1'b1);
    rst       = 1'b1;
    mem_state = 2'd3;
    @(negedge clk);
    check_eq("rst_rd_drop", dmem_if.rd, 1'b0);
    check_eq("rst_no_complete", complete_data, 1'b0);
    check_eq("rst_memout", memout, '0);
    check_eq("rst_addr", dmem_if.addr, '0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_after_complete", complete_data, 1'b0);
    check_eq("rst_after_rd", dmem_if.rd, 1'b0);
    memout_m = '0;
    ptr_m    = '0;
    ind_m    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    mem_state    = 2'd3;
    M_Addr       = '0;
    M_Data       = '0;
    dmem_if.ack  = 1'b0;
    dmem_if.dout = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_rd", dmem_if.rd, 1'b0);
    check_eq("reset_wr", dmem_if.wr, 1'b0);
    check_eq("reset_addr", dmem_if.addr, '0);
    check_eq("reset_din", dmem_if.din, '0);
    check_eq("reset_complete", complete_data, 1'b0);
    check_eq("reset_err", mem_err, 1'b0);
    check_eq("reset_memout", memout, '0);
    rst = 1'b0;
    @(negedge clk);

    // LD with ack on the third request cycle
    mem_m[32'h3000] = 16'hBEEF;
    run_txn(2'd0, 16'h3000, DW'($urandom), 2, 1'b0);
    check_eq("ld_memout", memout, 16'hBEEF);

    // LDI: pointer fetch then load through the pointer
    mem_m[32'h3010] = 16'h4000;
    mem_m[32'h4000] = 16'h1234;
    run_txn(2'd1, 16'h3010, DW'($urandom), 1, 1'b0);
    run_txn(2'd0, 16'h9999, DW'($urandom), 0, 1'b0);
    check_eq("ldi_memout", memout, 16'h1234);
    run_txn(2'd2, 16'h3333, 16'h0F0F, 0, 1'b0);

    // STI: write lands at the fetched pointer, memout untouched
    mem_m[32'h3020] = 16'h5000;
    run_txn(2'd1, 16'h3020, DW'($urandom), 0, 1'b0);
    run_txn(2'd2, 16'h7777, 16'hA5A5, 3, 1'b0);
    check_eq("sti_memout", memout, 16'h1234);

    // Timeout
    run_txn(2'd0, 16'h3040, DW'($urandom), -1, 1'b0);
    check_eq("timeout_memout", memout, '0);

    // Idle command abandons a half-done indirect
    mem_m[32'h3050] = 16'h6000;
    run_txn(2'd1, 16'h3050, DW'($urandom), 0, 1'b0);
    idle_cycles(1);
    run_txn(2'd0, 16'h3100, DW'($urandom), 1, 1'b0);

    // Slow controller keeps the read command up across completion
    run_txn(2'd0, 16'h3200, DW'($urandom), 0, 1'b1);
    run_txn(2'd0, 16'h3200, DW'($urandom), 2, 1'b1);
    run_txn(2'd0, 16'h3200, DW'($urandom), 0, 1'b0);

    // Ack on the very cycle the counter reaches TIMEOUT
    run_txn(2'd2, 16'h3300, 16'h1357, TO, 1'b0);

    reset_mid_access();

    for (int i = 0; i < 80; i++) begin
      logic [1:0] c;
      int dly;
      c   = 2'($urandom);
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO));
      if (c == 2'd3) idle_cycles(int'($urandom_range(1, 3)));
      else run_txn(c, DW'($urandom_range(16'h3000, 16'h301F)), DW'($urandom), dly,
                   1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
